// File: rtl/id_decode_ctrl.sv
// Decode-stage front controller: classifies fetched instructions, drives the sext block,
// and buffers decoded entries (output + skid) toward EX over valid/ready.
module id_decode_ctrl #(
    parameter int              XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush_i,
    input  logic            if_valid_i,
    output logic            if_ready_o,
    input  logic [XLEN-1:0] if_inst_i,
    input  logic [XLEN-1:0] if_pc_i,
    output logic [24:0]     sext_imm_o,
    output logic [2:0]      sext_type_o,
    output logic            sext_shift_o,
    input  logic [XLEN-1:0] sext_out_i,
    input  logic            ex_ready_i,
    output logic            id_valid_o,
    output logic [XLEN-1:0] id_pc_o,
    output logic [2:0]      id_inst_type_o,
    output logic [XLEN-1:0] id_imm_o,
    output logic [4:0]      id_rd_o,
    output logic [4:0]      id_rs1_o,
    output logic [4:0]      id_rs2_o,
    output logic            id_illegal_o
);

    localparam logic [2:0] INST_R = 3'd0;
    localparam logic [2:0] INST_I = 3'd1;
    localparam logic [2:0] INST_S = 3'd2;
    localparam logic [2:0] INST_B = 3'd3;
    localparam logic [2:0] INST_U = 3'd4;
    localparam logic [2:0] INST_J = 3'd5;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } state_t;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [2:0]      itype;
        logic [XLEN-1:0] imm;
        logic [4:0]      rd;
        logic [4:0]      rs1;
        logic [4:0]      rs2;
        logic            illegal;
    } entry_t;

    state_t state_q, state_d;
    entry_t out_q, out_d;
    entry_t skid_q, skid_d;
    logic   valid_q, valid_d;
    logic   ready_q, ready_d;

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic [2:0] dec_type;
    logic       dec_shift;
    logic       dec_illegal;
    logic       accept;
    entry_t     new_entry;

    assign opcode = if_inst_i[6:0];
    assign funct3 = if_inst_i[14:12];

    always_comb begin
        dec_type    = INST_R;
        dec_shift   = 1'b0;
        dec_illegal = 1'b0;
        case (opcode)
            7'b0010011: begin
                dec_type  = INST_I;
                dec_shift = (funct3 == 3'b001) || (funct3 == 3'b101);
            end
            7'b0000011, 7'b1100111, 7'b1110011: dec_type = INST_I;
            7'b0100011:                         dec_type = INST_S;
            7'b1100011:                         dec_type = INST_B;
            7'b0110111, 7'b0010111:             dec_type = INST_U;
            7'b1101111:                         dec_type = INST_J;
            7'b0110011:                         dec_type = INST_R;
            default:                            dec_illegal = 1'b1;
        endcase
    end

    assign sext_imm_o   = if_inst_i[31:7];
    assign sext_type_o  = dec_type;
    assign sext_shift_o = dec_shift;

    assign accept = if_valid_i & ready_q & ~flush_i;

    always_comb begin
        new_entry.pc      = if_pc_i;
        new_entry.itype   = dec_type;
        new_entry.imm     = sext_out_i;
        new_entry.rd      = if_inst_i[11:7];
        new_entry.rs1     = if_inst_i[19:15];
        new_entry.rs2     = if_inst_i[24:20];
        new_entry.illegal = dec_illegal;
    end

    // The output register only changes on a load, so id_* hold while EX stalls.
    always_comb begin
        state_d = state_q;
        out_d   = out_q;
        skid_d  = skid_q;
        if (flush_i) begin
            state_d = ST_EMPTY;
        end else begin
            case (state_q)
                ST_EMPTY: begin
                    if (accept) begin
                        out_d   = new_entry;
                        state_d = ST_ONE;
                    end
                end
                ST_ONE: begin
                    if (ex_ready_i) begin
                        if (accept) begin
                            out_d = new_entry;
                        end else begin
                            state_d = ST_EMPTY;
                        end
                    end else if (accept) begin
                        skid_d  = new_entry;
                        state_d = ST_TWO;
                    end
                end
                ST_TWO: begin
                    if (ex_ready_i) begin
                        out_d   = skid_q;
                        state_d = ST_ONE;
                    end
                end
                default: state_d = ST_EMPTY;
            endcase
        end
        valid_d = (state_d != ST_EMPTY);
        ready_d = (state_d != ST_TWO);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_EMPTY;
            out_q      <= '0;
            out_q.pc   <= RESET_PC;
            skid_q     <= '0;
            valid_q    <= 1'b0;
            ready_q    <= 1'b1;
        end else begin
            state_q    <= state_d;
            out_q      <= out_d;
            skid_q     <= skid_d;
            valid_q    <= valid_d;
            ready_q    <= ready_d;
        end
    end

    assign if_ready_o     = ready_q;
    assign id_valid_o     = valid_q;
    assign id_pc_o        = out_q.pc;
    assign id_inst_type_o = out_q.itype;
    assign id_imm_o       = out_q.imm;
    assign id_rd_o        = out_q.rd;
    assign id_rs1_o       = out_q.rs1;
    assign id_rs2_o       = out_q.rs2;
    assign id_illegal_o   = out_q.illegal;

endmodule

// File: tb/tb_id_decode_ctrl.sv
// Bench for id_decode_ctrl: emulates the sext block and checks every entry EX consumes
// against an in-order scoreboard, plus directed reset/flush/stall scenarios.
module tb_id_decode_ctrl;

    localparam logic [31:0] RST_PC = 32'h0000_0100;
    localparam logic [2:0]  T_R = 3'd0, T_I = 3'd1, T_S = 3'd2, T_B = 3'd3, T_U = 3'd4, T_J = 3'd5;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        flush_i = 1'b0;
    logic        if_valid_i = 1'b0;
    logic        if_ready_o;
    logic [31:0] if_inst_i = 32'h0;
    logic [31:0] if_pc_i = 32'h0;
    logic [24:0] sext_imm_o;
    logic [2:0]  sext_type_o;
    logic        sext_shift_o;
    logic [31:0] sext_out_i;
    logic        ex_ready_i = 1'b0;
    logic        id_valid_o;
    logic [31:0] id_pc_o;
    logic [2:0]  id_inst_type_o;
    logic [31:0] id_imm_o;
    logic [4:0]  id_rd_o, id_rs1_o, id_rs2_o;
    logic        id_illegal_o;

    int total = 0;
    int bad = 0;

    typedef logic [82:0] ent_t;
    ent_t sb_q[$];

    id_decode_ctrl #(.XLEN(32), .RESET_PC(RST_PC)) dut (
        .clk(clk), .rst(rst), .flush_i(flush_i),
        .if_valid_i(if_valid_i), .if_ready_o(if_ready_o),
        .if_inst_i(if_inst_i), .if_pc_i(if_pc_i),
        .sext_imm_o(sext_imm_o), .sext_type_o(sext_type_o), .sext_shift_o(sext_shift_o),
        .sext_out_i(sext_out_i), .ex_ready_i(ex_ready_i),
        .id_valid_o(id_valid_o), .id_pc_o(id_pc_o), .id_inst_type_o(id_inst_type_o),
        .id_imm_o(id_imm_o), .id_rd_o(id_rd_o), .id_rs1_o(id_rs1_o), .id_rs2_o(id_rs2_o),
        .id_illegal_o(id_illegal_o)
    );

    always #5 clk = ~clk;

    // External sext block: works on imm_in = inst[31:7], so inst[k] is sext_imm_o[k-7].
    always_comb begin
        sext_out_i = 32'h0;
        case (sext_type_o)
            T_I: sext_out_i = sext_shift_o ? {27'b0, sext_imm_o[17:13]}
                                           : {{20{sext_imm_o[24]}}, sext_imm_o[24:13]};
            T_S: sext_out_i = {{20{sext_imm_o[24]}}, sext_imm_o[24:18], sext_imm_o[4:0]};
            T_B: sext_out_i = {{19{sext_imm_o[24]}}, sext_imm_o[24], sext_imm_o[0],
                               sext_imm_o[23:18], sext_imm_o[4:1], 1'b0};
            T_U: sext_out_i = {sext_imm_o[24:5], 12'b0};
            T_J: sext_out_i = {{11{sext_imm_o[24]}}, sext_imm_o[24], sext_imm_o[12:5],
                               sext_imm_o[13], sext_imm_o[23:14], 1'b0};
            default: sext_out_i = 32'h0;
        endcase
    end

    function automatic ent_t model(input logic [31:0] inst, input logic [31:0] pc);
        logic [2:0]  t;
        logic        ill;
        logic [31:0] imm;
        t   = T_R;
        ill = 1'b0;
        imm = 32'h0;
        case (inst[6:0])
            7'b0010011: begin
                t = T_I;
                if (inst[14:12] == 3'b001 || inst[14:12] == 3'b101) imm = {27'b0, inst[24:20]};
                else imm = {{20{inst[31]}}, inst[31:20]};
            end
            7'b0000011, 7'b1100111, 7'b1110011: begin
                t = T_I;
                imm = {{20{inst[31]}}, inst[31:20]};
            end
            7'b0100011: begin t = T_S; imm = {{20{inst[31]}}, inst[31:25], inst[11:7]}; end
            7'b1100011: begin
                t = T_B;
                imm = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
            end
            7'b0110111, 7'b0010111: begin t = T_U; imm = {inst[31:12], 12'b0}; end
            7'b1101111: begin
                t = T_J;
                imm = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
            end
            7'b0110011: t = T_R;
            default: ill = 1'b1;
        endcase
        return {pc, t, imm, inst[11:7], inst[19:15], inst[24:20], ill};
    endfunction

    // Scoreboard and output-hold monitor; inputs change just after posedge, so the
    // negedge view equals what the DUT sees at the following posedge.
    ent_t prev_ent;
    logic prev_hold = 1'b0;
    always @(negedge clk) begin
        ent_t act, exp_e;
        act = {id_pc_o, id_inst_type_o, id_imm_o, id_rd_o, id_rs1_o, id_rs2_o, id_illegal_o};
        if (rst) begin
            sb_q.delete();
            prev_hold = 1'b0;
        end else begin
            if (prev_hold) begin
                total++;
                if (!id_valid_o || act !== prev_ent) begin
                    bad++;
                    $display("FAIL hold: got valid=%0b ent=%h, need valid=1 ent=%h", id_valid_o, act, prev_ent);
                end
            end
            prev_hold = id_valid_o && !ex_ready_i && !flush_i;
            prev_ent  = act;
            if (flush_i) begin
                sb_q.delete();
            end else begin
                if (id_valid_o && ex_ready_i) begin
                    total++;
                    if (sb_q.size() == 0) begin
                        bad++;
                        $display("FAIL sb_extra: got entry pc=%h, need none", id_pc_o);
                    end else begin
                        exp_e = sb_q.pop_front();
                        if (act !== exp_e) begin
                            bad++;
                            $display("FAIL sb_entry: got %h, need %h", act, exp_e);
                        end
                    end
                end
                if (if_valid_i && if_ready_o) sb_q.push_back(model(if_inst_i, if_pc_i));
            end
        end
    end

    // Offer one instruction and return at posedge+1 after it has been accepted.
    task automatic send(input logic [31:0] inst, input logic [31:0] pc);
        bit ok;
        ok = 1'b0;
        if_valid_i = 1'b1;
        if_inst_i  = inst;
        if_pc_i    = pc;
        for (int n = 0; n < 50; n++) begin
            @(negedge clk);
            if (if_ready_o && !flush_i) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            total++;
            bad++;
            $display("FAIL send_timeout: got if_ready=0 for 50 cycles, need 1 (inst %h)", inst);
        end
        @(posedge clk);
        #1;
        if_valid_i = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        total++;
        if ({id_valid_o, if_ready_o} !== 2'b01) begin
            bad++;
            $display("FAIL reset_hs: got valid=%0b ready=%0b, need valid=0 ready=1", id_valid_o, if_ready_o);
        end
        total++;
        if ({id_pc_o, id_inst_type_o, id_imm_o, id_rd_o, id_rs1_o, id_rs2_o, id_illegal_o}
                !== {RST_PC, 51'b0}) begin
            bad++;
            $display("FAIL reset_out: got pc=%h imm=%h type=%0d, need pc=%h rest 0", id_pc_o, id_imm_o, id_inst_type_o, RST_PC);
        end
        rst = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset_mid;
        ex_ready_i = 1'b0;
        send(32'hFFF00093, 32'h0000_2000);
        send(32'h12345037, 32'h0000_2004);
        total++;
        if (if_ready_o !== 1'b0) begin
            bad++;
            $display("FAIL mid_two_ready: got %0b, need 0", if_ready_o);
        end
        #2;
        rst = 1'b1;
        #1;
        total++;
        if ({id_valid_o, if_ready_o, id_pc_o, id_imm_o} !== {2'b01, RST_PC, 32'h0}) begin
            bad++;
            $display("FAIL async_reset: got valid=%0b ready=%0b pc=%h imm=%h, need 0 1 %h 0",
                     id_valid_o, if_ready_o, id_pc_o, id_imm_o, RST_PC);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        ex_ready_i = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        total++;
        if (id_valid_o !== 1'b0) begin
            bad++;
            $display("FAIL reset_replay: got valid=%0b, need 0", id_valid_o);
        end
    endtask

    task automatic test_addi;
        ex_ready_i = 1'b1;
        send(32'hFFF00093, 32'h0000_1000);
        total++;
        if ({id_valid_o, id_inst_type_o, id_imm_o, id_rd_o} !== {1'b1, T_I, 32'hFFFF_FFFF, 5'd1}) begin
            bad++;
            $display("FAIL addi: got valid=%0b type=%0d imm=%h rd=%0d, need 1 %0d ffffffff 1",
                     id_valid_o, id_inst_type_o, id_imm_o, id_rd_o, T_I);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_slli;
        logic [31:0] inst;
        inst = 32'h00509093;
        ex_ready_i = 1'b1;
        if_inst_i  = inst;
        #1;
        total++;
        if ({sext_shift_o, sext_type_o, sext_imm_o} !== {1'b1, T_I, inst[31:7]}) begin
            bad++;
            $display("FAIL slli_sext: got shift=%0b type=%0d imm_in=%h, need 1 %0d %h",
                     sext_shift_o, sext_type_o, sext_imm_o, T_I, inst[31:7]);
        end
        send(inst, 32'h0000_1004);
        total++;
        if ({id_valid_o, id_imm_o, id_rs1_o} !== {1'b1, 32'h5, 5'd1}) begin
            bad++;
            $display("FAIL slli: got valid=%0b imm=%h rs1=%0d, need 1 00000005 1", id_valid_o, id_imm_o, id_rs1_o);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_back_to_back;
        ex_ready_i = 1'b0;
        send(32'h0020A423, 32'h0000_3000);
        send(32'h12345037, 32'h0000_3004);
        for (int c = 0; c < 2; c++) begin
            total++;
            if ({if_ready_o, id_valid_o, id_inst_type_o, id_imm_o} !== {2'b01, T_S, 32'd8}) begin
                bad++;
                $display("FAIL b2b_stall%0d: got ready=%0b valid=%0b type=%0d imm=%h, need 0 1 %0d 8",
                         c, if_ready_o, id_valid_o, id_inst_type_o, id_imm_o, T_S);
            end
            @(posedge clk);
            #1;
        end
        ex_ready_i = 1'b1;
        @(posedge clk);
        #1;
        total++;
        if ({if_ready_o, id_valid_o, id_inst_type_o, id_imm_o, id_pc_o}
                !== {2'b11, T_U, 32'h1234_5000, 32'h0000_3004}) begin
            bad++;
            $display("FAIL b2b_release: got ready=%0b valid=%0b type=%0d imm=%h pc=%h, need 1 1 %0d 12345000 00003004",
                     if_ready_o, id_valid_o, id_inst_type_o, id_imm_o, id_pc_o, T_U);
        end
        @(posedge clk);
        #1;
        total++;
        if (id_valid_o !== 1'b0) begin
            bad++;
            $display("FAIL b2b_drain: got valid=%0b, need 0", id_valid_o);
        end
    endtask

    task automatic test_flush;
        ex_ready_i = 1'b0;
        send(32'h00100113, 32'h0000_4000);
        send(32'h00200193, 32'h0000_4004);
        if_valid_i = 1'b1;
        if_inst_i  = 32'h00300213;
        if_pc_i    = 32'h0000_4008;
        flush_i    = 1'b1;
        @(posedge clk);
        #1;
        flush_i    = 1'b0;
        if_valid_i = 1'b0;
        total++;
        if ({id_valid_o, if_ready_o} !== 2'b01) begin
            bad++;
            $display("FAIL flush: got valid=%0b ready=%0b, need 0 1", id_valid_o, if_ready_o);
        end
        ex_ready_i = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        total++;
        if (id_valid_o !== 1'b0) begin
            bad++;
            $display("FAIL flush_leak: got valid=%0b, need 0", id_valid_o);
        end
    endtask

    task automatic test_illegal;
        ex_ready_i = 1'b1;
        send(32'h0000007F, 32'h0000_5000);
        total++;
        if ({id_valid_o, id_illegal_o, id_inst_type_o, id_imm_o} !== {2'b11, T_R, 32'h0}) begin
            bad++;
            $display("FAIL illegal: got valid=%0b ill=%0b type=%0d imm=%h, need 1 1 %0d 0",
                     id_valid_o, id_illegal_o, id_inst_type_o, id_imm_o, T_R);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_random;
        logic [6:0]  ops [11];
        logic [31:0] r;
        ops = '{7'b0010011, 7'b0000011, 7'b1100111, 7'b1110011, 7'b0100011, 7'b1100011,
                7'b0110111, 7'b0010111, 7'b1101111, 7'b0110011, 7'b1011011};
        for (int c = 0; c < 400; c++) begin
            r = $urandom();
            if_inst_i  = {r[31:7], ops[$urandom_range(0, 10)]};
            if_pc_i    = 32'h0001_0000 + 32'(c * 4);
            if_valid_i = ($urandom_range(0, 3) != 0);
            ex_ready_i = ($urandom_range(0, 2) != 0);
            flush_i    = ($urandom_range(0, 39) == 0);
            @(posedge clk);
            #1;
        end
        if_valid_i = 1'b0;
        flush_i    = 1'b0;
        ex_ready_i = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        total++;
        if (sb_q.size() != 0 || id_valid_o !== 1'b0) begin
            bad++;
            $display("FAIL random_drain: got %0d pending valid=%0b, need 0 pending valid=0", sb_q.size(), id_valid_o);
        end
    endtask

    initial begin
        test_reset;
        test_addi;
        test_slli;
        test_back_to_back;
        test_flush;
        test_illegal;
        test_reset_mid;
        test_random;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
